icache_tag_array: RTL and testbench

- Parametrised N-way tag store for the instruction cache: per-way tag RAM plus per-way valid bits, indexed by set.
- Single-cycle registered lookup with built-in tag compare, producing a per-way hit vector.
- Multi-way masked write.
- Sequential flush engine that walks every set; reset reuses the same walk. Sits between the icache controller and the data-way arrays.

---
 rtl/icache_tag_array.sv | 158 +++++++++++++++
 tb/tb_icache_tag_array.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_tag_array.sv
// rtl/icache_tag_array.sv - N-way icache tag store with registered lookup/compare and set-walking flush
// Optional ICACHE_TAG_PARITY_EN adds a per-entry even-parity bit and a parity_err_o port.
module icache_tag_array #(
    parameter int NUM_WAYS  = 4,
    parameter int DEPTH     = 256,
    parameter int TAG_WIDTH = 20
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_i,
    output logic                          ready_o,
    input  logic                          we_i,
    input  logic [NUM_WAYS-1:0]           way_sel_i,
    input  logic [$clog2(DEPTH)-1:0]      set_i,
    input  logic [TAG_WIDTH-1:0]          tag_i,
    input  logic                          vbit_i,
    input  logic                          flush_i,
    output logic                          busy_o,
    output logic                          rvalid_o,
    output logic [NUM_WAYS*TAG_WIDTH-1:0] tags_o,
    output logic [NUM_WAYS-1:0]           vbits_o,
    output logic [NUM_WAYS-1:0]           hit_way_o,
    output logic                          hit_o,
`ifdef ICACHE_TAG_PARITY_EN
    output logic [NUM_WAYS-1:0]           parity_err_o,
`endif
    output logic                          multi_hit_o
);

    localparam int SET_W = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                     state_q;
    logic [SET_W-1:0]           flush_cnt_q;

    logic [TAG_WIDTH-1:0]       tag_mem [NUM_WAYS][DEPTH];
    logic [DEPTH-1:0]           vld_mem [NUM_WAYS];
`ifdef ICACHE_TAG_PARITY_EN
    logic                       par_mem [NUM_WAYS][DEPTH];
    logic [NUM_WAYS-1:0]        rd_perr;
`endif

    logic                          accept;
    logic                          do_lookup;
    logic                          do_write;
    logic [NUM_WAYS*TAG_WIDTH-1:0] rd_tags;
    logic [NUM_WAYS-1:0]           rd_vld;
    logic [NUM_WAYS-1:0]           rd_hit;
    logic                          rd_multi;

    assign ready_o   = (state_q == ST_IDLE) & ~flush_i;
    assign busy_o    = (state_q == ST_FLUSH);
    assign accept    = req_i & ready_o & ~rst_i;
    assign do_lookup = accept & ~we_i;
    assign do_write  = accept & we_i;

    // Flush walk: one set per cycle; reset enters the same walk from set 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flush_i) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == SET_W'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                    end
                    flush_cnt_q <= flush_cnt_q + SET_W'(1);
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag (and parity) storage carries no reset; hits are always qualified by valid bits.
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (do_write && way_sel_i[w]) begin
                tag_mem[w][set_i] <= tag_i;
`ifdef ICACHE_TAG_PARITY_EN
                par_mem[w][set_i] <= ^tag_i;
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (state_q == ST_FLUSH) begin
                    vld_mem[w][flush_cnt_q] <= 1'b0;
                end else if (do_write && way_sel_i[w]) begin
                    vld_mem[w][set_i] <= vbit_i;
                end
            end
        end
    end

    always_comb begin
        rd_tags = '0;
        rd_vld  = '0;
        rd_hit  = '0;
`ifdef ICACHE_TAG_PARITY_EN
        rd_perr = '0;
`endif
        for (int w = 0; w < NUM_WAYS; w++) begin
            rd_tags[w*TAG_WIDTH +: TAG_WIDTH] = tag_mem[w][set_i];
            rd_vld[w] = vld_mem[w][set_i];
            rd_hit[w] = vld_mem[w][set_i] & (tag_mem[w][set_i] == tag_i);
`ifdef ICACHE_TAG_PARITY_EN
            rd_perr[w] = vld_mem[w][set_i] & ((^tag_mem[w][set_i]) != par_mem[w][set_i]);
            rd_hit[w]  = rd_hit[w] & ~rd_perr[w];
`endif
        end
    end

    // Clearing the lowest set bit leaves something only if two or more ways hit.
    assign rd_multi = |(rd_hit & (rd_hit - NUM_WAYS'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o     <= 1'b0;
            tags_o       <= '0;
            vbits_o      <= '0;
            hit_way_o    <= '0;
            hit_o        <= 1'b0;
            multi_hit_o  <= 1'b0;
`ifdef ICACHE_TAG_PARITY_EN
            parity_err_o <= '0;
`endif
        end else begin
            rvalid_o <= do_lookup;
            if (do_lookup) begin
                tags_o       <= rd_tags;
                vbits_o      <= rd_vld;
                hit_way_o    <= rd_hit;
                hit_o        <= |rd_hit;
                multi_hit_o  <= rd_multi;
`ifdef ICACHE_TAG_PARITY_EN
                parity_err_o <= rd_perr;
`endif
            end
        end
    end

endmodule

// File: tb/tb_icache_tag_array.sv
// tb/tb_icache_tag_array.sv - randomized self-checking bench for icache_tag_array against an array model
module tb_icache_tag_array;

    localparam int NW = 4;
    localparam int DP = 256;
    localparam int TW = 20;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          ready;
    logic          we;
    logic [NW-1:0] way_sel;
    logic [SW-1:0] set;
    logic [TW-1:0] tag;
    logic          vbit;
    logic          flush;
    logic          busy;
    logic          rvalid;
    logic [NW*TW-1:0] tags;
    logic [NW-1:0] vbits;
    logic [NW-1:0] hit_way;
    logic          hit;
    logic          multi_hit;
`ifdef ICACHE_TAG_PARITY_EN
    logic [NW-1:0] parity_err;
`endif

    always #5 clk = ~clk;

    icache_tag_array #(.NUM_WAYS(NW), .DEPTH(DP), .TAG_WIDTH(TW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .ready_o     (ready),
        .we_i        (we),
        .way_sel_i   (way_sel),
        .set_i       (set),
        .tag_i       (tag),
        .vbit_i      (vbit),
        .flush_i     (flush),
        .busy_o      (busy),
        .rvalid_o    (rvalid),
        .tags_o      (tags),
        .vbits_o     (vbits),
        .hit_way_o   (hit_way),
        .hit_o       (hit),
`ifdef ICACHE_TAG_PARITY_EN
        .parity_err_o(parity_err),
`endif
        .multi_hit_o (multi_hit)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // Reference model: plain arrays of what each entry should hold.
    logic [TW-1:0] m_tag   [NW][DP];
    bit            m_vld   [NW][DP];
    bit            m_known [NW][DP];
    int            m_left;
    logic [NW*TW-1:0] e_tags, e_mask;
    logic [NW-1:0] e_vbits, e_hit;
    logic          e_hit_any, e_multi, e_rvalid;

    task automatic model_reset();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < DP; s++)
                m_vld[w][s] = 1'b0;
        m_left    = DP;
        e_tags    = '0;
        e_mask    = '1;
        e_vbits   = '0;
        e_hit     = '0;
        e_hit_any = 1'b0;
        e_multi   = 1'b0;
        e_rvalid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; flush = 1'b0;
        way_sel = '0; set = '0; tag = '0; vbit = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("rst_rvalid", rvalid, 0);
        check("rst_tags", tags, 0);
        check("rst_vbits", vbits, 0);
        check("rst_hitway", hit_way, 0);
        check("rst_hit", hit, 0);
        check("rst_multi", multi_hit, 0);
        check("rst_busy", busy, 1);
        check("rst_ready", ready, 0);
    endtask

    task automatic drive_cycle(input bit r, input bit w, input logic [NW-1:0] ws,
                               input logic [SW-1:0] s, input logic [TW-1:0] t,
                               input bit v, input bit f);
        bit exp_ready;
        bit acc;
        int nh;
        req = r; we = w; way_sel = ws; set = s; tag = t; vbit = v; flush = f;
        #1;
        exp_ready = (m_left == 0) && !f;
        check("ready", ready, exp_ready);
        check("busy", busy, m_left > 0);
        acc = r && exp_ready;
        e_rvalid = acc && !w;
        if (acc && !w) begin
            nh = 0;
            for (int wy = 0; wy < NW; wy++) begin
                e_tags[wy*TW +: TW] = m_known[wy][s] ? m_tag[wy][s] : '0;
                e_mask[wy*TW +: TW] = m_known[wy][s] ? '1 : '0;
                e_vbits[wy] = m_vld[wy][s];
                e_hit[wy]   = m_vld[wy][s] && m_known[wy][s] && (m_tag[wy][s] == t);
                nh += int'(e_hit[wy]);
            end
            e_hit_any = (nh > 0);
            e_multi   = (nh > 1);
        end
        if (acc && w) begin
            for (int wy = 0; wy < NW; wy++) begin
                if (ws[wy]) begin
                    m_tag[wy][s]   = t;
                    m_vld[wy][s]   = v;
                    m_known[wy][s] = 1'b1;
                end
            end
        end
        if (m_left > 0) begin
            m_left--;
        end else if (f) begin
            m_left = DP;
            for (int wy = 0; wy < NW; wy++)
                for (int k = 0; k < DP; k++)
                    m_vld[wy][k] = 1'b0;
        end
        @(posedge clk); #1;
        req = 1'b0; flush = 1'b0;
        check("rvalid", rvalid, e_rvalid);
        check("tags", tags & e_mask, e_tags & e_mask);
        check("vbits", vbits, e_vbits);
        check("hit_way", hit_way, e_hit);
        check("hit", hit, e_hit_any);
        check("multi_hit", multi_hit, e_multi);
`ifdef ICACHE_TAG_PARITY_EN
        check("parity_err", parity_err, 0);
`endif
    endtask

    task automatic idle();
        drive_cycle(0, 0, '0, '0, '0, 0, 0);
    endtask

    logic [TW-1:0] pool [4];
    int n;

    initial begin
        pool[0] = 20'h11111; pool[1] = 20'h2A2A2; pool[2] = 20'h0F0F0; pool[3] = 20'hFFFFE;
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < DP; s++)
                m_known[w][s] = 1'b0;

        // Reset walk length
        do_reset();
        n = 0;
        repeat (260) begin
            if (busy) n++;
            idle();
        end
        check("rst_busy_len", n, 256);
        check("rst_ready_after", ready, 1);

        drive_cycle(1, 0, '0, 8'h00, 20'h12345, 0, 0);
        check("t1_rvalid", rvalid, 1);
        check("t1_vbits", vbits, 0);
        check("t1_hit", hit, 0);

        drive_cycle(1, 1, 4'b0100, 8'h3A, 20'hABCDE, 1, 0);
        drive_cycle(1, 0, '0, 8'h3A, 20'hABCDE, 0, 0);
        check("t2_hitway", hit_way, 4'b0100);
        check("t2_hit", hit, 1);
        check("t2_multi", multi_hit, 0);
        drive_cycle(1, 0, '0, 8'h3A, 20'hABCDF, 0, 0);
        check("t2_miss", hit, 0);

        drive_cycle(1, 1, 4'b1001, 8'h05, 20'h00F00, 1, 0);
        drive_cycle(1, 0, '0, 8'h05, 20'h00F00, 0, 0);
        check("t3_hitway", hit_way, 4'b1001);
        check("t3_multi", multi_hit, 1);

        // Back-to-back lookups
        drive_cycle(1, 1, 4'b0001, 8'h01, 20'h00001, 1, 0);
        drive_cycle(1, 1, 4'b0010, 8'h02, 20'h00002, 1, 0);
        drive_cycle(1, 1, 4'b1100, 8'h03, 20'h00003, 1, 0);
        drive_cycle(1, 0, '0, 8'h01, 20'h00001, 0, 0);
        check("b2b_1", hit_way, 4'b0001);
        drive_cycle(1, 0, '0, 8'h02, 20'h00002, 0, 0);
        check("b2b_2", hit_way, 4'b0010);
        drive_cycle(1, 0, '0, 8'h03, 20'h00003, 0, 0);
        check("b2b_3", hit_way, 4'b1100);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            int op;
            op = int'($urandom_range(0, 299));
            if (op < 2)
                drive_cycle($urandom_range(0, 1) != 0, 0, '0, SW'($urandom_range(0, 7)),
                            pool[$urandom_range(0, 3)], 0, 1);
            else if (op < 130)
                drive_cycle(1, 0, '0, SW'($urandom_range(0, 7)), pool[$urandom_range(0, 3)], 0, 0);
            else if (op < 230)
                drive_cycle(1, 1, NW'($urandom_range(0, 15)), SW'($urandom_range(0, 7)),
                            pool[$urandom_range(0, 3)], $urandom_range(0, 3) != 0, 0);
            else
                idle();
        end
        while (m_left > 0) idle();

        // Flush colliding with a request, second flush pulse mid-walk
        drive_cycle(1, 1, 4'b0100, 8'h3A, 20'hABCDE, 1, 0);
        drive_cycle(1, 1, 4'b1111, 8'h3A, 20'h99999, 1, 1);
        n = 0;
        for (int i = 0; i < 270; i++) begin
            if (busy) n++;
            drive_cycle(0, 0, '0, '0, '0, 0, i == 99);
        end
        check("flush_busy_len", n, 256);
        drive_cycle(1, 0, '0, 8'h3A, 20'hABCDE, 0, 0);
        check("flush_vbits", vbits, 0);
        check("flush_tag_kept", tags[2*TW +: TW], 20'hABCDE);
        check("flush_hit", hit, 0);

        // Reset in the middle of a walk restarts it
        drive_cycle(0, 0, '0, '0, '0, 0, 1);
        repeat (50) idle();
        do_reset();
        n = 0;
        repeat (260) begin
            if (busy) n++;
            idle();
        end
        check("rst_mid_busy_len", n, 256);

`ifdef ICACHE_TAG_PARITY_EN
        drive_cycle(1, 1, 4'b0010, 8'h10, 20'h55555, 1, 0);
        dut.tag_mem[1][16] = 20'h55554;
        req = 1'b1; we = 1'b0; set = 8'h10; tag = 20'h55554;
        @(posedge clk); #1;
        req = 1'b0;
        check("par_hit1", hit_way[1], 0);
        check("par_err", parity_err, 4'b0010);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
